// File: rtl/mem_arbiter.sv
// Two-master DataMem arbiter with a registered read-return owner tag.
// Define MEM_ARB_RR_EN for round-robin arbitration and the bounded m1 lock.
module mem_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_wr,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic        m0_gnt,
  output logic        m0_rvalid,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_wr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic        m1_lock,
  output logic        m1_gnt,
  output logic        m1_rvalid,
  output logic [31:0] m1_rdata,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    OWN0,
    OWN1
  } state_e;

  state_e state_q, state_d;
  logic   gnt0, gnt1;
  logic   rd_vld_q, rd_vld_d;
  logic   rd_own_q, rd_own_d;

`ifdef MEM_ARB_RR_EN
  localparam int HW = $clog2(MAX_HOLD + 1);

  logic [HW-1:0] hold_q, hold_d;
  logic          lock_win;

  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    hold_d   = '0;
    lock_win = (state_q == OWN1) && m1_lock
               && (hold_q < HW'(MAX_HOLD));
    if (m0_req && m1_req) begin
      // lock wins while under budget, else last-owner round robin
      gnt1 = lock_win || (state_q == OWN0);
      gnt0 = !gnt1;
    end else begin
      gnt0 = m0_req;
      gnt1 = m1_req;
    end
    if (gnt1 && m1_lock) begin
      if (hold_q < HW'(MAX_HOLD)) hold_d = hold_q + HW'(1);
      else                        hold_d = hold_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) hold_q <= '0;
    else        hold_q <= hold_d;
  end
`else
  localparam int unused_max_hold = MAX_HOLD;
  logic unused_lock;

  assign unused_lock = m1_lock;

  always_comb begin
    gnt0 = m0_req;
    gnt1 = m1_req && !m0_req;
  end
`endif

  always_comb begin
    state_d  = IDLE;
    rd_vld_d = 1'b0;
    rd_own_d = 1'b0;
    unique case (1'b1)
      gnt0: begin
        state_d  = OWN0;
        rd_vld_d = !m0_wr;
      end
      gnt1: begin
        state_d  = OWN1;
        rd_vld_d = !m1_wr;
        rd_own_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      rd_vld_q <= 1'b0;
      rd_own_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_vld_d;
      rd_own_q <= rd_own_d;
    end
  end

  assign m0_gnt = gnt0;
  assign m1_gnt = gnt1;

  assign mem_rd = (gnt0 && !m0_wr) || (gnt1 && !m1_wr);
  assign mem_wr = (gnt0 && m0_wr) || (gnt1 && m1_wr);

  assign mem_addr  = gnt0 ? m0_addr  : (gnt1 ? m1_addr  : '0);
  assign mem_wdata = gnt0 ? m0_wdata : (gnt1 ? m1_wdata : '0);

  // return steered by the tag, not by this cycle's grant
  assign m0_rvalid = rd_vld_q && !rd_own_q;
  assign m1_rvalid = rd_vld_q && rd_own_q;
  assign m0_rdata  = m0_rvalid ? mem_rdata : '0;
  assign m1_rdata  = m1_rvalid ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter; expectations follow MEM_ARB_RR_EN.
// Inputs change just after negedge, outputs sampled 1 time unit later.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        m0_req, m0_wr;
  logic [31:0] m0_addr, m0_wdata;
  logic        m0_gnt, m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m1_req, m1_wr, m1_lock;
  logic [31:0] m1_addr, m1_wdata;
  logic        m1_gnt, m1_rvalid;
  logic [31:0] m1_rdata;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int n_cmp = 0;
  int n_err = 0;

`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  mem_arbiter #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .m0_req    (m0_req),
    .m0_wr     (m0_wr),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_wr     (m1_wr),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_lock   (m1_lock),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_ctl"},
        {26'd0, m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_rd, mem_wr},
        32'd0);
    chk({tag, "_data"},
        m0_rdata | m1_rdata | mem_addr | mem_wdata, 32'd0);
  endtask

  task automatic nxt();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    logic        exp1, prev1;
    int          k;
    logic [31:0] ea;

    reset = 1'b0;
    m0_req = 0; m0_wr = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_wr = 0; m1_addr = 0; m1_wdata = 0;
    m1_lock = 0; mem_rdata = 32'hA5A5_A5A5;

    // reset held low 3 cycles
    repeat (3) @(negedge clk);
    #1 chk_quiet("in_reset");
    @(negedge clk);
    reset = 1'b1;
    #1 chk_quiet("post_reset");
    nxt();
    #1 chk_quiet("idle_cycle");

    // m0 read, addr 0x10
    m0_req = 1; m0_wr = 0; m0_addr = 32'h10;
    #1;
    chk("rd_m0_gnt", {31'd0, m0_gnt}, 32'd1);
    chk("rd_m1_gnt", {31'd0, m1_gnt}, 32'd0);
    chk("rd_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rd_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rd_addr", mem_addr, 32'h10);
    nxt();
    m0_req = 0; mem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("rd_m0_rvalid", {31'd0, m0_rvalid}, 32'd1);
    chk("rd_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
    chk("rd_m1_rvalid", {31'd0, m1_rvalid}, 32'd0);
    chk("rd_m1_rdata", m1_rdata, 32'd0);
    chk("rd_mem_rd_off", {31'd0, mem_rd}, 32'd0);

    // m0 write, no return expected
    nxt();
    m0_req = 1; m0_wr = 1; m0_addr = 32'h20;
    m0_wdata = 32'hCAFE_F00D;
    #1;
    chk("wr_mem_wr", {31'd0, mem_wr}, 32'd1);
    chk("wr_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("wr_wdata", mem_wdata, 32'hCAFE_F00D);
    chk("wr_addr", mem_addr, 32'h20);
    nxt();
    m0_req = 0; m0_wr = 0; mem_rdata = 32'h55;
    #1;
    chk("wr_no_rvalid", {30'd0, m0_rvalid, m1_rvalid}, 32'd0);
    chk("wr_rdata_zero", m0_rdata, 32'd0);

    // simultaneous reads from IDLE
    nxt();
    prev1 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m0_req = 1; m0_wr = 0; m0_addr = 32'h40;
      m1_req = 1; m1_wr = 0; m1_addr = 32'h80;
      mem_rdata = 32'h1000 + i;
      exp1 = RR ? i[0] : 1'b0;
      #1;
      chk($sformatf("sim%0d_gnt", i),
          {30'd0, m0_gnt, m1_gnt}, exp1 ? 32'd1 : 32'd2);
      chk($sformatf("sim%0d_addr", i),
          mem_addr, exp1 ? 32'h80 : 32'h40);
      if (i > 0) begin
        chk($sformatf("sim%0d_rv", i),
            {30'd0, m0_rvalid, m1_rvalid}, prev1 ? 32'd1 : 32'd2);
        chk($sformatf("sim%0d_rdata", i),
            prev1 ? m1_rdata : m0_rdata, 32'h1000 + i);
      end
      prev1 = exp1;
      nxt();
    end
    m0_req = 0; m1_req = 0; mem_rdata = 32'h1004;
    #1;
    chk("sim_last_rv",
        {30'd0, m0_rvalid, m1_rvalid}, prev1 ? 32'd1 : 32'd2);
    chk("sim_last_rdata", prev1 ? m1_rdata : m0_rdata, 32'h1004);
    nxt();

    // m0 owns first, then locked m1 burst against m0
    m0_req = 1; m0_wr = 1; m0_addr = 32'h200; m0_wdata = 32'h0;
    #1 chk("pre_lock_m0", {31'd0, m0_gnt}, 32'd1);
    nxt();
    k = 0;
    for (int c = 1; c <= 13; c++) begin
      m1_req = 1; m1_lock = 1; m1_wr = 1;
      m1_addr = 32'h100 + 32'(4 * k); m1_wdata = 32'(k);
      exp1 = RR ? (c != 9) : 1'b0;
      ea   = exp1 ? 32'h100 + 32'(4 * k) : 32'h200;
      #1;
      chk($sformatf("lock%0d_gnt", c),
          {30'd0, m0_gnt, m1_gnt}, exp1 ? 32'd1 : 32'd2);
      chk($sformatf("lock%0d_addr", c), mem_addr, ea);
      if (exp1) k++;
      nxt();
    end
    m0_req = 0; m0_wr = 0; m1_req = 0; m1_lock = 0; m1_wr = 0;
    #1 chk_quiet("after_lock");
    nxt();

    // m1 read then reset during the return cycle
    m1_req = 1; m1_wr = 0; m1_addr = 32'h300;
    #1;
    chk("rst_m1_gnt", {31'd0, m1_gnt}, 32'd1);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd1);
    chk("rst_addr", mem_addr, 32'h300);
    nxt();
    m1_req = 0; mem_rdata = 32'h77; reset = 1'b0;
    #1 chk_quiet("rst_mid");
    @(negedge clk);
    reset = 1'b1;
    #1 chk_quiet("rst_release");
    nxt();
    #1 chk_quiet("rst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MAX_HOLD, default 8, giving the maximum consecutive grants to master 1 while it holds the lock.
REQ-002 The block SHALL have port clk, input, 1 bit, system clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-004 The block SHALL have port m0_req, input, 1 bit, CPU data-port access request.
REQ-005 The block SHALL have ports m0_wr (input, 1), m0_addr (input, 32) and m0_wdata (input, 32), giving CPU write strobe, byte address and write data.
REQ-006 The block SHALL have ports m0_gnt (output, 1), m0_rvalid (output, 1) and m0_rdata (output, 32), giving CPU grant, read-return strobe and read data.
REQ-007 The block SHALL have ports m1_req, m1_wr, m1_addr, m1_wdata, m1_gnt, m1_rvalid and m1_rdata, identical in direction and width to the m0 set, for the DMA/loader master.
REQ-008 The block SHALL have port m1_lock, input, 1 bit; while set with m1_req, master 1 requests back-to-back ownership (burst).
REQ-009 The block SHALL have ports mem_rd (output, 1), mem_wr (output, 1), mem_addr (output, 32) and mem_wdata (output, 32), forming the DataMem command.
REQ-010 The block SHALL have port mem_rdata, input, 32 bits, DataMem read data, valid in the cycle after mem_rd.

Function
REQ-011 Arbitration SHALL be a state machine with states IDLE, OWN0 and OWN1, recording the last granted master.
REQ-012 Grant SHALL be combinational in the request cycle: at most one of m0_gnt/m1_gnt is high, and the granted master's wr/addr/wdata drive mem_*.
REQ-013 mem_rd SHALL equal gnt AND NOT wr of the granted master; mem_wr SHALL equal gnt AND wr; both SHALL be 0 with no grant.
REQ-014 A granted read SHALL return mem_rdata on the owner's rdata, with that master's rvalid pulsing high for exactly one cycle, one cycle after the grant (latency 1).
REQ-015 The rvalid/rdata return SHALL be steered by a registered owner tag, so a different grant in the return cycle does not corrupt it.
REQ-016 With only one master requesting, that master SHALL be granted every cycle.
REQ-017 Simultaneous requests, no lock: the master not granted last SHALL be granted (round-robin); from IDLE, m0 wins.
REQ-018 Lock: while in OWN1 with m1_req and m1_lock both high, m1 SHALL keep the grant regardless of m0_req.
REQ-019 The lock SHALL be held for at most MAX_HOLD consecutive grants; the next cycle with m0_req high SHALL then grant m0, after which the hold counter clears.
REQ-020 The hold counter SHALL saturate at MAX_HOLD, never wrap, and clear on any m0 grant or m1_lock deassertion.
REQ-021 A cycle with no request SHALL return the state to IDLE, drive no grant and leave the hold counter cleared.
REQ-022 An ungranted master SHALL keep its request and command stable until granted; the arbiter SHALL NOT latch ungranted commands.

Reset
REQ-023 On reset low, state SHALL be IDLE, hold counter 0, owner tag invalid, all gnt/rvalid/mem_rd/mem_wr 0, rdata and mem_addr/mem_wdata 0.
REQ-024 A reset asserted mid-transaction SHALL suppress the pending rvalid; no return pulse SHALL occur after reset release.

Configuration
REQ-025 With macro MEM_ARB_RR_EN defined, REQ-017 to REQ-020 SHALL apply as written.
REQ-026 Without MEM_ARB_RR_EN, m0 SHALL always win simultaneous requests, m1_lock SHALL be ignored, and the hold counter SHALL be absent; all other requirements SHALL be unchanged.

Verification
REQ-027 Reset held low 3 cycles, then released with no requests -> all outputs 0, state IDLE, no rvalid.
REQ-028 m0 read, addr 0x00000010, with memory returning 0xDEADBEEF -> m0_gnt=1 and mem_rd=1 in cycle N; m0_rvalid=1 and m0_rdata=0xDEADBEEF in N+1; m1_rvalid stays 0.
REQ-029 m0 and m1 request simultaneously for 4 cycles, no lock (RR_EN) -> grants m0,m1,m0,m1; rdata returns to the matching master one cycle after each grant.
REQ-030 m1 locked burst of 12 writes (addr 0x100 step 4) with m0_req held high, MAX_HOLD=8 -> m1 granted 8 consecutive cycles, m0 granted in cycle 9, m1 resumes in cycle 10.
REQ-031 Build without MEM_ARB_RR_EN, both masters requesting continuously -> m0_gnt=1 every cycle, m1_gnt never asserts.
REQ-032 m1 read granted in cycle N, reset pulsed low during N+1 -> m1_rvalid stays 0, all outputs 0 until the next request.
